// File: rtl/lab1_part2_irq_pkg.sv
// Shared constants for the lab1 part2 interrupt controller.
package lab1_part2_irq_pkg;

   localparam logic [2:0] IRQ_ADDR_STATUS  = 3'd0;
   localparam logic [2:0] IRQ_ADDR_PENDING = 3'd1;
   localparam logic [2:0] IRQ_ADDR_MASK    = 3'd2;
   localparam logic [2:0] IRQ_ADDR_EDGE    = 3'd3;
   localparam logic [2:0] IRQ_ADDR_ACTIVE  = 3'd4;
   localparam logic [2:0] IRQ_ADDR_VECTOR  = 3'd5;
   localparam logic [2:0] IRQ_ADDR_FORCE   = 3'd6;

   localparam int unsigned IRQ_VEC_VALID_BIT = 15;
   localparam int unsigned IRQ_MAX_SOURCES   = 16;

endpackage

// File: rtl/lab1_part2_irq_prio_enc.sv
// Combinational priority encoder: lowest-numbered set bit wins.
module lab1_part2_irq_prio_enc
   import lab1_part2_irq_pkg::*;
#(
   parameter int unsigned NUM_IRQ = 8
) (
   input  logic [NUM_IRQ-1:0] active,
   output logic               valid,
   output logic [3:0]         index
);

   // Scan high to low so the last hit (lowest index) is the one kept.
   always_comb begin
      valid = 1'b0;
      index = 4'd0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (active[i]) begin
            valid = 1'b1;
            index = i[3:0];
         end
      end
   end

endmodule

// File: rtl/lab1_part2_irq_ctrl.sv
// Avalon-MM interrupt controller: pending/mask/edge registers, single cpu_irq.
module lab1_part2_irq_ctrl
   import lab1_part2_irq_pkg::*;
#(
   parameter int unsigned NUM_IRQ = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [2:0]         address,
   input  logic               chipselect,
   input  logic               write_n,
   input  logic [15:0]        writedata,
   output logic [15:0]        readdata,
   input  logic [NUM_IRQ-1:0] irq_in,
   output logic               cpu_irq
);

   logic [NUM_IRQ-1:0] irq_d;
   logic [NUM_IRQ-1:0] pending;
   logic [NUM_IRQ-1:0] pending_next;
   logic [NUM_IRQ-1:0] mask;
   logic [NUM_IRQ-1:0] edge_sel;
   logic [NUM_IRQ-1:0] active;
   logic [NUM_IRQ-1:0] set_bits;
   logic [NUM_IRQ-1:0] clr_bits;
   logic [NUM_IRQ-1:0] wdata;
   logic               wr;
   logic               vec_valid;
   logic [3:0]         vec_index;
   logic [15:0]        readdata_next;
   logic [15:0]        status_ext;
   logic [15:0]        pending_ext;
   logic [15:0]        mask_ext;
   logic [15:0]        edge_ext;
   logic [15:0]        active_ext;
   logic               unused_wdata;

   assign wr           = chipselect & ~write_n;
   assign wdata        = writedata[NUM_IRQ-1:0];
   assign unused_wdata = ^writedata;
   assign active       = pending & mask;

   lab1_part2_irq_prio_enc #(
      .NUM_IRQ (NUM_IRQ)
   ) u_prio_enc (
      .active (active),
      .valid  (vec_valid),
      .index  (vec_index)
   );

   // Set sources: level, rising edge, or software force; set beats clear.
   always_comb begin
      set_bits = (~edge_sel & irq_in) | (edge_sel & irq_in & ~irq_d);
      clr_bits = '0;
      if (wr && address == IRQ_ADDR_FORCE) begin
         set_bits = set_bits | wdata;
      end
      if (wr && address == IRQ_ADDR_PENDING) begin
         clr_bits = wdata;
      end
      pending_next = (pending & ~clr_bits) | set_bits;
   end

   // Zero-extend the per-source vectors to the 16-bit bus.
   always_comb begin
      status_ext  = '0;
      pending_ext = '0;
      mask_ext    = '0;
      edge_ext    = '0;
      active_ext  = '0;
      status_ext[NUM_IRQ-1:0]  = irq_in;
      pending_ext[NUM_IRQ-1:0] = pending;
      mask_ext[NUM_IRQ-1:0]    = mask;
      edge_ext[NUM_IRQ-1:0]    = edge_sel;
      active_ext[NUM_IRQ-1:0]  = active;
   end

   // Read mux; reflects register state before the capturing edge.
   always_comb begin
      readdata_next = '0;
      unique case (address)
         IRQ_ADDR_STATUS:  readdata_next = status_ext;
         IRQ_ADDR_PENDING: readdata_next = pending_ext;
         IRQ_ADDR_MASK:    readdata_next = mask_ext;
         IRQ_ADDR_EDGE:    readdata_next = edge_ext;
         IRQ_ADDR_ACTIVE:  readdata_next = active_ext;
         IRQ_ADDR_VECTOR: begin
            readdata_next[IRQ_VEC_VALID_BIT] = vec_valid;
            readdata_next[3:0]               = vec_index;
         end
         default:          readdata_next = '0;
      endcase
   end

   // Register file, edge-detect history, pending and outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_d    <= '0;
         pending  <= '0;
         mask     <= '0;
         edge_sel <= '0;
         readdata <= '0;
         cpu_irq  <= 1'b0;
      end else begin
         irq_d    <= irq_in;
         pending  <= pending_next;
         readdata <= readdata_next;
         cpu_irq  <= |active;
         if (wr && address == IRQ_ADDR_MASK) begin
            mask <= wdata;
         end
         if (wr && address == IRQ_ADDR_EDGE) begin
            edge_sel <= wdata;
         end
      end
   end

endmodule

// File: tb/tb_lab1_part2_irq_ctrl.sv
// Directed self-checking bench for lab1_part2_irq_ctrl (NUM_IRQ = 8).
module tb_lab1_part2_irq_ctrl;
   import lab1_part2_irq_pkg::*;

   logic        clk;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [15:0] writedata;
   logic [15:0] readdata;
   logic [7:0]  irq_in;
   logic        cpu_irq;

   int n_checks;
   int n_fails;

   lab1_part2_irq_ctrl #(
      .NUM_IRQ (8)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .irq_in     (irq_in),
      .cpu_irq    (cpu_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b0;
      writedata  = d;
      step();
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   task automatic rd_check(input string tag, input logic [2:0] a, input logic [15:0] exp);
      address = a;
      step();
      check(tag, readdata, exp);
   endtask

   initial begin
      n_checks   = 0;
      n_fails    = 0;
      reset_n    = 1'b0;
      address    = '0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      irq_in     = '0;
      step();
      step();
      reset_n = 1'b1;
      step();

      // Reset state: all addresses read zero
      for (int a = 0; a < 8; a++) begin
         rd_check($sformatf("reset_rd%0d", a), 3'(a), 16'h0000);
      end
      check("reset_cpu_irq", {15'd0, cpu_irq}, 16'h0000);

      // Level mode on source 0
      wr(IRQ_ADDR_MASK, 16'h0001);
      irq_in = 8'h01;
      step();
      check("lvl_cpu_irq_lag", {15'd0, cpu_irq}, 16'h0000);
      rd_check("lvl_pending", IRQ_ADDR_PENDING, 16'h0001);
      check("lvl_cpu_irq", {15'd0, cpu_irq}, 16'h0001);
      wr(IRQ_ADDR_PENDING, 16'h0001);
      rd_check("lvl_w1c_held", IRQ_ADDR_PENDING, 16'h0001);
      irq_in = 8'h00;
      wr(IRQ_ADDR_PENDING, 16'h0001);
      check("lvl_w1c_cpu_lag", {15'd0, cpu_irq}, 16'h0001);
      rd_check("lvl_w1c_clear", IRQ_ADDR_PENDING, 16'h0000);
      check("lvl_w1c_cpu_irq", {15'd0, cpu_irq}, 16'h0000);

      // Edge mode, single-cycle pulse on source 2
      wr(IRQ_ADDR_EDGE, 16'h0004);
      wr(IRQ_ADDR_MASK, 16'h0004);
      rd_check("edge_reg", IRQ_ADDR_EDGE, 16'h0004);
      irq_in = 8'h04;
      step();
      irq_in = 8'h00;
      rd_check("edge_pending", IRQ_ADDR_PENDING, 16'h0004);
      rd_check("edge_vector", IRQ_ADDR_VECTOR, 16'h8002);
      check("edge_cpu_irq", {15'd0, cpu_irq}, 16'h0001);
      wr(IRQ_ADDR_PENDING, 16'h0004);
      irq_in = 8'h04;
      step();
      wr(IRQ_ADDR_PENDING, 16'h0004);
      step();
      rd_check("edge_held_noset", IRQ_ADDR_PENDING, 16'h0000);
      rd_check("status_raw", IRQ_ADDR_STATUS, 16'h0004);
      irq_in = 8'h00;

      // Masked source still latches
      wr(IRQ_ADDR_MASK, 16'h0000);
      irq_in = 8'h08;
      step();
      irq_in = 8'h00;
      rd_check("masked_pending", IRQ_ADDR_PENDING, 16'h0008);
      rd_check("masked_active", IRQ_ADDR_ACTIVE, 16'h0000);
      check("masked_cpu_irq", {15'd0, cpu_irq}, 16'h0000);
      wr(IRQ_ADDR_MASK, 16'h0008);
      check("unmask_cpu_lag", {15'd0, cpu_irq}, 16'h0000);
      step();
      check("unmask_cpu_irq", {15'd0, cpu_irq}, 16'h0001);
      rd_check("unmask_active", IRQ_ADDR_ACTIVE, 16'h0008);
      wr(IRQ_ADDR_PENDING, 16'h0008);

      // Priority vector and FORCE
      wr(IRQ_ADDR_MASK, 16'h0023);
      irq_in = 8'h22;
      step();
      irq_in = 8'h00;
      rd_check("vec_1_5", IRQ_ADDR_VECTOR, 16'h8001);
      wr(IRQ_ADDR_PENDING, 16'h0002);
      rd_check("vec_5", IRQ_ADDR_VECTOR, 16'h8005);
      wr(IRQ_ADDR_FORCE, 16'h0001);
      rd_check("vec_force", IRQ_ADDR_VECTOR, 16'h8000);
      rd_check("force_reads0", IRQ_ADDR_FORCE, 16'h0000);
      rd_check("force_pending", IRQ_ADDR_PENDING, 16'h0021);
      rd_check("reserved_rd", 3'd7, 16'h0000);

      // Edge rise coincident with W1C: set wins
      wr(IRQ_ADDR_PENDING, 16'h00ff);
      wr(IRQ_ADDR_EDGE, 16'h0001);
      rd_check("cleared_all", IRQ_ADDR_PENDING, 16'h0000);
      irq_in = 8'h01;
      wr(IRQ_ADDR_PENDING, 16'h0001);
      rd_check("set_wins", IRQ_ADDR_PENDING, 16'h0001);
      check("set_wins_cpu_irq", {15'd0, cpu_irq}, 16'h0001);

      // Asynchronous reset mid-sequence
      #2;
      reset_n = 1'b0;
      #1;
      check("async_rst_cpu_irq", {15'd0, cpu_irq}, 16'h0000);
      check("async_rst_readdata", readdata, 16'h0000);
      irq_in = 8'h00;
      #1;
      reset_n = 1'b1;
      for (int a = 0; a < 8; a++) begin
         rd_check($sformatf("post_rst_rd%0d", a), 3'(a), 16'h0000);
      end
      check("post_rst_cpu_irq", {15'd0, cpu_irq}, 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
